lpgbt_scrambler_mc: RTL and testbench
=====================================

# lpgbt_scrambler_mc

Parametrised, multi-channel multiplicative scrambler/descrambler for the lpGBT-FE datapath. It generalises the fixed 60-bit order-58 uplink scrambler to any frame width, polynomial order and tap, with NCH independent lanes. A MODE parameter selects the transmit scrambler or the matching self-synchronising receive descrambler. Inputs are valid-qualified, bypass switches cleanly, and each lane has a resync and a flush/lock indication. It sits between the FEC encoder and the gearbox on TX, and between the gearbox and the FEC decoder on RX.

## Interface
- WIDTH, 60: bits per lane per word.
- ORDER, 58: polynomial order. Legal range is 2 ≤ ORDER ≤ WIDTH.
- TAP_A, 39: inner tap. Legal range is 1 ≤ TAP_A < ORDER.
- NCH, 1: number of lanes (1..8).
- MODE, 0: 0 selects scramble, 1 selects descramble.
- INIT_SEED, {ORDER{1'b1}}: history value loaded at reset and at resync, identical for all lanes.
- clock  in  1  datapath clock.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  word qualifier for all lanes.
- in_data  in  NCH*WIDTH  lane c occupies bits [c*WIDTH +: WIDTH].
- bypass  in  1  pass-through select, sampled with in_valid.
- resync  in  NCH  per-lane history reload, single-cycle pulse.
- out_valid  out  1  registered copy of in_valid.
- out_data  out  NCH*WIDTH  scrambled, descrambled or bypassed words.
- out_flushed  out  NCH  lane history is derived from live data.
- word_count  out  32  count of valid words processed, wraps at 2^32.

## Operation
- **Bit ordering.** Within a word, bit j of word k is serial bit n = k*WIDTH + j; bit 0 is the oldest bit.
- **Per-lane history.** H is ORDER bits and holds the last ORDER bits of the scrambled-domain stream: the output stream when MODE=0, the input stream when MODE=1.
- **Scramble (MODE=0).** s[n] = d[n] XNOR s[n−TAP_A] XNOR s[n−ORDER].
  - Terms with a negative in-word index are taken from H.
  - Terms within the current word are computed in the same cycle; the recursion is unrolled combinationally.
- **Descramble (MODE=1).** d[n] = r[n] XNOR r[n−TAP_A] XNOR r[n−ORDER]. This is feed-forward only.
- **On a valid cycle** (in_valid=1, bypass=0):
  - Output is the computed word.
  - H ← top ORDER bits of the scrambled-domain word, i.e. bits [WIDTH−1 : WIDTH−ORDER].
- **On a bypass cycle** (in_valid=1, bypass=1):
  - out_data = in_data.
  - H is unchanged and out_flushed is unchanged.
- **When in_valid=0:** H, out_data, out_flushed and word_count all hold. out_valid ← 0.
- **resync[c]=1:**
  - Lane c H ← INIT_SEED and out_flushed[c] ← 0.
  - If the same cycle is valid, the word is processed with INIT_SEED as its history, H is then updated from that word, and out_flushed[c] ← 1 for MODE=1 (0 for MODE=0).
  - resync overrides only the history source; it does not suppress the word.
- **out_flushed.**
  - MODE=1: set on the first non-bypass valid word after reset or resync (ORDER ≤ WIDTH, so one word flushes H).
  - MODE=0: stays 0; it has no meaning there.
- **word_count.** Increments on every in_valid=1 cycle, including bypass cycles.
- **Reset.** Forces H ← INIT_SEED and clears all outputs to 0. It dominates all other inputs.

## Timing
- Latency is 1 clock from in_valid/in_data to out_valid/out_data, for all modes and bypass.
- There is no backpressure; a new word may be presented every cycle.
- bypass takes effect on the word sampled in the same cycle; switching does not insert a gap.
- The combinational path is at most ORDER/TAP-deep XNOR chains per bit for MODE=0. Register input only if timing fails, and then raise latency to 2 globally. That option is not part of v1.

## Test plan
- **All-ones steady state.** WIDTH=60, ORDER=58, TAP_A=39, MODE=0, seed all-ones. Reset, then feed 10 valid words of 60'hFFF_FFFF_FFFF_FFFF → out_data = all-ones every word, word_count=10, out_valid one cycle after each in_valid.
- **Loopback.** A MODE=0 instance feeds a MODE=1 instance, both with the same seed. Send 1000 random words → descrambler output equals the original input from word 0. Repeat with the descrambler seed set to 0 → mismatch on word 0 only, exact match from word 1, out_flushed rises after word 0.
- **Bypass burst.** Alternate 3 scrambled, 2 bypassed, 3 scrambled words → bypassed words appear unchanged. The final 3 words equal a reference model in which the bypassed words are removed from the stream.
- **Valid gaps.** Deassert in_valid for 5 cycles mid-stream → out_data holds, out_valid=0, and the stream resumes identical to a gap-free reference.
- **Multi-channel resync.** NCH=4, pulse resync[2] on a valid cycle → only lane 2 restarts from INIT_SEED (matches a fresh-reset model), and only out_flushed[2] drops then re-rises. Lanes 0, 1 and 3 are unaffected.
- **Reset mid-stream.** Assert reset together with in_valid on word 50 → the next cycle shows all outputs 0 and word_count=0. Post-reset output is identical to the output after the initial reset.

Source files
------------

// File: rtl/lpgbt_scrambler_mc_if.sv
// Word interface of the multi-channel lpGBT scrambler/descrambler.
//   in_valid     word qualifier shared by all lanes
//   in_data      NCH lanes of WIDTH bits, lane c at [c*WIDTH +: WIDTH]
//   bypass       pass-through select, qualified by in_valid
//   resync       per-lane history reload pulse
//   out_valid    registered copy of in_valid
//   out_data     processed (or bypassed) lanes
//   out_flushed  per-lane "history derived from live data"
//   word_count   valid words seen, wraps at 2^32
interface lpgbt_scrambler_mc_if #(
    parameter int unsigned NCH   = 1,
    parameter int unsigned WIDTH = 60
);
    logic                 in_valid;
    logic [NCH*WIDTH-1:0] in_data;
    logic                 bypass;
    logic [NCH-1:0]       resync;
    logic                 out_valid;
    logic [NCH*WIDTH-1:0] out_data;
    logic [NCH-1:0]       out_flushed;
    logic [31:0]          word_count;

    modport master (
        output in_valid, in_data, bypass, resync,
        input  out_valid, out_data, out_flushed, word_count
    );

    modport slave (
        input  in_valid, in_data, bypass, resync,
        output out_valid, out_data, out_flushed, word_count
    );
endinterface

// File: rtl/lpgbt_scrambler_mc.sv
// Parametrised multi-lane multiplicative scrambler (MODE=0) or self-synchronising
// descrambler (MODE=1). One clock of latency, no backpressure.
//   clock  datapath clock
//   reset  synchronous, active-high; loads INIT_SEED and clears all outputs
//   bus    lpgbt_scrambler_mc_if slave port (see interface header)
module lpgbt_scrambler_mc #(
    parameter int unsigned      WIDTH     = 60,
    parameter int unsigned      ORDER     = 58,
    parameter int unsigned      TAP_A     = 39,
    parameter int unsigned      NCH       = 1,
    parameter int unsigned      MODE      = 0,
    parameter logic [ORDER-1:0] INIT_SEED = {ORDER{1'b1}}
) (
    input logic                  clock,
    input logic                  reset,
    lpgbt_scrambler_mc_if.slave  bus
);

    // History layout: bit ORDER-1 is the newest serial bit (n-1), bit 0 the oldest (n-ORDER).
    // ext[] below concatenates word above history so serial bit n-k sits at ext[ORDER+j-k].
    function automatic logic [WIDTH-1:0] scramble(input logic [WIDTH-1:0] d,
                                                   input logic [ORDER-1:0] h);
        logic [ORDER+WIDTH-1:0] ext;
        ext = '0;
        ext[ORDER-1:0] = h;
        // Unrolled recursion: each output bit feeds later bits of the same word.
        for (int j = 0; j < int'(WIDTH); j++) begin
            ext[ORDER+j] = d[j] ~^ ext[ORDER+j-TAP_A] ~^ ext[j];
        end
        return ext[ORDER+WIDTH-1:ORDER];
    endfunction

    function automatic logic [WIDTH-1:0] descramble(input logic [WIDTH-1:0] r,
                                                     input logic [ORDER-1:0] h);
        logic [ORDER+WIDTH-1:0] ext;
        logic [WIDTH-1:0]       d;
        ext = {r, h};
        d   = '0;
        for (int j = 0; j < int'(WIDTH); j++) begin
            d[j] = ext[ORDER+j] ~^ ext[ORDER+j-TAP_A] ~^ ext[j];
        end
        return d;
    endfunction

    logic [ORDER-1:0]     hist_q [NCH];
    logic [ORDER-1:0]     hist_d [NCH];
    logic [NCH*WIDTH-1:0] data_q, data_d;
    logic [NCH-1:0]       flushed_q, flushed_d;
    logic                 valid_q;
    logic [31:0]          count_q, count_d;

    logic [WIDTH-1:0]     lane_in   [NCH];
    logic [WIDTH-1:0]     lane_out  [NCH];
    logic [WIDTH-1:0]     lane_sdom [NCH];
    logic [ORDER-1:0]     hist_src  [NCH];

    for (genvar c = 0; c < int'(NCH); c++) begin : g_lane
        assign lane_in[c] = bus.in_data[c*WIDTH +: WIDTH];
        // A resync on a valid cycle processes that word against the seed.
        assign hist_src[c] = bus.resync[c] ? INIT_SEED : hist_q[c];

        if (MODE == 0) begin : g_scr
            assign lane_out[c]  = scramble(lane_in[c], hist_src[c]);
            assign lane_sdom[c] = lane_out[c];
        end else begin : g_dsc
            assign lane_out[c]  = descramble(lane_in[c], hist_src[c]);
            assign lane_sdom[c] = lane_in[c];
        end
    end

    always_comb begin
        data_d    = data_q;
        flushed_d = flushed_q;
        count_d   = count_q;
        for (int c = 0; c < int'(NCH); c++) begin
            hist_d[c] = hist_q[c];
            if (bus.resync[c]) begin
                hist_d[c]    = INIT_SEED;
                flushed_d[c] = 1'b0;
            end
            if (bus.in_valid) begin
                if (bus.bypass) begin
                    data_d[c*WIDTH +: WIDTH] = lane_in[c];
                end else begin
                    data_d[c*WIDTH +: WIDTH] = lane_out[c];
                    hist_d[c]                = lane_sdom[c][WIDTH-1 -: ORDER];
                    // ORDER <= WIDTH, so one word fully replaces the history.
                    flushed_d[c]             = (MODE == 1);
                end
            end
        end
        if (bus.in_valid) begin
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q   <= 1'b0;
            data_q    <= '0;
            flushed_q <= '0;
            count_q   <= '0;
            for (int c = 0; c < int'(NCH); c++) begin
                hist_q[c] <= INIT_SEED;
            end
        end else begin
            valid_q   <= bus.in_valid;
            data_q    <= data_d;
            flushed_q <= flushed_d;
            count_q   <= count_d;
            for (int c = 0; c < int'(NCH); c++) begin
                hist_q[c] <= hist_d[c];
            end
        end
    end

    assign bus.out_valid   = valid_q;
    assign bus.out_data    = data_q;
    assign bus.out_flushed = flushed_q;
    assign bus.word_count  = count_q;

endmodule

// File: tb/tb_lpgbt_scrambler_mc.sv
// Bench: a full-size scrambler for the all-ones case, and a small 4-lane
// (WIDTH=8, ORDER=4, TAP_A=3) scrambler looped into two descramblers
// (seed all-ones and seed zero). Expected words are hand-computed.
module tb_lpgbt_scrambler_mc;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    lpgbt_scrambler_mc_if #(.NCH(1), .WIDTH(60)) big_if ();
    lpgbt_scrambler_mc_if #(.NCH(4), .WIDTH(8))  tx_if ();
    lpgbt_scrambler_mc_if #(.NCH(4), .WIDTH(8))  rx_if ();
    lpgbt_scrambler_mc_if #(.NCH(4), .WIDTH(8))  rx0_if ();

    lpgbt_scrambler_mc dut_big (
        .clock (clock),
        .reset (reset),
        .bus   (big_if.slave)
    );

    lpgbt_scrambler_mc #(
        .WIDTH(8), .ORDER(4), .TAP_A(3), .NCH(4), .MODE(0), .INIT_SEED(4'hF)
    ) dut_tx (
        .clock (clock),
        .reset (reset),
        .bus   (tx_if.slave)
    );

    lpgbt_scrambler_mc #(
        .WIDTH(8), .ORDER(4), .TAP_A(3), .NCH(4), .MODE(1), .INIT_SEED(4'hF)
    ) dut_rx (
        .clock (clock),
        .reset (reset),
        .bus   (rx_if.slave)
    );

    lpgbt_scrambler_mc #(
        .WIDTH(8), .ORDER(4), .TAP_A(3), .NCH(4), .MODE(1), .INIT_SEED(4'h0)
    ) dut_rx0 (
        .clock (clock),
        .reset (reset),
        .bus   (rx0_if.slave)
    );

    // Descramblers take the scrambler output directly.
    assign rx_if.in_valid  = tx_if.out_valid;
    assign rx_if.in_data   = tx_if.out_data;
    assign rx0_if.in_valid = tx_if.out_valid;
    assign rx0_if.in_data  = tx_if.out_data;

    typedef struct packed {
        logic [59:0] data;
        logic [31:0] count;
    } big_exp_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  flushed;
        logic [31:0] count;
    } sm_exp_t;

    big_exp_t big_q [$];
    sm_exp_t  tx_q  [$];
    sm_exp_t  rx_q  [$];
    sm_exp_t  rx0_q [$];

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    logic [31:0] cnt_big;
    logic [31:0] cnt_sm;
    logic        prev_byp;
    logic [3:0]  prev_rsy;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic extra(input string name, input logic [63:0] act);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: unexpected output word %h, required none", name, act);
    endtask

    // ---------------- monitors ----------------
    always @(negedge clock) begin
        big_exp_t e;
        if (big_if.out_valid === 1'b1) begin
            if (big_q.size() == 0) begin
                extra("big_extra", 64'(big_if.out_data));
            end else begin
                e = big_q.pop_front();
                check("big_data", 64'(big_if.out_data), 64'(e.data));
                check("big_count", 64'(big_if.word_count), 64'(e.count));
            end
        end
    end

    always @(negedge clock) begin
        sm_exp_t e;
        if (tx_if.out_valid === 1'b1) begin
            if (tx_q.size() == 0) begin
                extra("tx_extra", 64'(tx_if.out_data));
            end else begin
                e = tx_q.pop_front();
                check("tx_data", 64'(tx_if.out_data), 64'(e.data));
                check("tx_flushed", 64'(tx_if.out_flushed), 64'(e.flushed));
                check("tx_count", 64'(tx_if.word_count), 64'(e.count));
            end
        end
    end

    always @(negedge clock) begin
        sm_exp_t e;
        if (rx_if.out_valid === 1'b1) begin
            if (rx_q.size() == 0) begin
                extra("rx_extra", 64'(rx_if.out_data));
            end else begin
                e = rx_q.pop_front();
                check("rx_loopback", 64'(rx_if.out_data), 64'(e.data));
                check("rx_flushed", 64'(rx_if.out_flushed), 64'(e.flushed));
                check("rx_count", 64'(rx_if.word_count), 64'(e.count));
            end
        end
    end

    always @(negedge clock) begin
        sm_exp_t e;
        if (rx0_if.out_valid === 1'b1) begin
            if (rx0_q.size() == 0) begin
                extra("rx0_extra", 64'(rx0_if.out_data));
            end else begin
                e = rx0_q.pop_front();
                check("rx0_data", 64'(rx0_if.out_data), 64'(e.data));
                check("rx0_flushed", 64'(rx0_if.out_flushed), 64'(e.flushed));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step_big(input logic v, input logic [59:0] d, input logic [59:0] e);
        @(negedge clock);
        big_if.in_valid = v;
        big_if.in_data  = d;
        if (v) begin
            cnt_big = cnt_big + 32'd1;
            big_q.push_back('{data: e, count: cnt_big});
        end
    endtask

    // One small-config cycle; descramblers get bypass/resync one cycle late so they
    // line up with the scrambler output word.
    task automatic step(input logic v, input logic b, input logic [3:0] r,
                        input logic [31:0] d, input logic [31:0] e_tx,
                        input logic [31:0] e_rx0, input logic [3:0] e_fl);
        @(negedge clock);
        tx_if.in_valid = v;
        tx_if.bypass   = b;
        tx_if.resync   = r;
        tx_if.in_data  = d;
        rx_if.bypass   = prev_byp;
        rx_if.resync   = prev_rsy;
        rx0_if.bypass  = prev_byp;
        rx0_if.resync  = prev_rsy;
        prev_byp = b;
        prev_rsy = r;
        if (v) begin
            cnt_sm = cnt_sm + 32'd1;
            tx_q.push_back('{data: e_tx, flushed: 4'h0, count: cnt_sm});
            rx_q.push_back('{data: d, flushed: e_fl, count: cnt_sm});
            rx0_q.push_back('{data: e_rx0, flushed: e_fl, count: cnt_sm});
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_big_valid"}, 64'(big_if.out_valid), 64'h0);
        check({tag, "_big_data"}, 64'(big_if.out_data), 64'h0);
        check({tag, "_big_count"}, 64'(big_if.word_count), 64'h0);
        check({tag, "_tx_valid"}, 64'(tx_if.out_valid), 64'h0);
        check({tag, "_tx_data"}, 64'(tx_if.out_data), 64'h0);
        check({tag, "_tx_count"}, 64'(tx_if.word_count), 64'h0);
        check({tag, "_rx_data"}, 64'(rx_if.out_data), 64'h0);
        check({tag, "_rx_flushed"}, 64'(rx_if.out_flushed), 64'h0);
        check({tag, "_rx0_flushed"}, 64'(rx0_if.out_flushed), 64'h0);
        check({tag, "_rx_count"}, 64'(rx_if.word_count), 64'h0);
    endtask

    // First three words after any reset: lanes {3,2,1,0}.
    task automatic opening_words();
        step(1'b1, 1'b0, 4'h0, 32'h0000_0000, 32'hC8C8_C8C8, 32'h0808_0808, 4'hF);
        step(1'b1, 1'b0, 4'h0, 32'h0000_0000, 32'h7A7A_7A7A, 32'h0000_0000, 4'hF);
        step(1'b1, 1'b0, 4'h0, 32'hFF0F_A500, 32'h5323_F964, 32'hFF0F_A500, 4'hF);
    endtask

    initial begin
        reset           = 1'b1;
        big_if.in_valid = 1'b0;
        big_if.in_data  = '0;
        big_if.bypass   = 1'b0;
        big_if.resync   = '0;
        tx_if.in_valid  = 1'b0;
        tx_if.in_data   = '0;
        tx_if.bypass    = 1'b0;
        tx_if.resync    = '0;
        rx_if.bypass    = 1'b0;
        rx_if.resync    = '0;
        rx0_if.bypass   = 1'b0;
        rx0_if.resync   = '0;
        prev_byp        = 1'b0;
        prev_rsy        = '0;
        cnt_big         = '0;
        cnt_sm          = '0;

        repeat (3) @(negedge clock);
        check_zero("reset");
        reset = 1'b0;

        // All-ones is a fixed point of the full-size scrambler from an all-ones seed.
        for (int i = 0; i < 10; i++) begin
            step_big(1'b1, {60{1'b1}}, {60{1'b1}});
        end
        // Zero word from all-ones history: only bits 39..57 pick up a single history 1.
        step_big(1'b1, 60'h0, 60'h3FF_FF80_0000_0000);
        step_big(1'b0, 60'h0, 60'h0);

        // Small config: scrambled, bypass burst, resync on lane 2, valid gap.
        opening_words();
        step(1'b1, 1'b1, 4'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'hF);
        step(1'b1, 1'b1, 4'h0, 32'h0123_4567, 32'h0123_4567, 32'h0123_4567, 4'hF);
        step(1'b1, 1'b0, 4'b0100, 32'h0, 32'h8FC8_C83D, 32'h0008_0000, 4'hF);
        idle();
        idle();
        step(1'b0, 1'b0, 4'b0100, 32'h0, 32'h0, 32'h0, 4'h0);
        idle();
        idle();
        check("gap_tx_valid", 64'(tx_if.out_valid), 64'h0);
        check("gap_tx_hold", 64'(tx_if.out_data), 64'h8FC8_C83D);
        check("gap_rx0_hold", 64'(rx0_if.out_data), 64'h0008_0000);
        check("gap_rx_flushed", 64'(rx_if.out_flushed), 64'hB);
        check("gap_rx0_flushed", 64'(rx0_if.out_flushed), 64'hB);
        step(1'b1, 1'b0, 4'h0, 32'h0, 32'hACC8_7AB2, 32'h0008_0000, 4'hF);
        step(1'b1, 1'b0, 4'h0, 32'h0, 32'h477A_641E, 32'h0000_0000, 4'hF);
        idle();
        idle();

        // Reset together with a valid word on both configurations.
        @(negedge clock);
        reset           = 1'b1;
        big_if.in_valid = 1'b1;
        big_if.in_data  = 60'h123_4567_89AB_CDEF;
        tx_if.in_valid  = 1'b1;
        tx_if.in_data   = 32'hCAFE_F00D;
        tx_if.resync    = 4'hF;
        @(negedge clock);
        check_zero("midreset");
        reset           = 1'b0;
        big_if.in_valid = 1'b0;
        tx_if.in_valid  = 1'b0;
        tx_if.resync    = '0;
        prev_byp        = 1'b0;
        prev_rsy        = '0;
        cnt_sm          = '0;

        opening_words();
        idle();
        idle();
        idle();

        check("big_drain", 64'(big_q.size()), 64'h0);
        check("tx_drain", 64'(tx_q.size()), 64'h0);
        check("rx_drain", 64'(rx_q.size()), 64'h0);
        check("rx0_drain", 64'(rx0_q.size()), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
